data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 28 ++
 rtl/data_cache_array.sv | 52 +++++
 rtl/data_cache.sv | 207 ++++++++++++++++++++
 tb/tb_data_cache.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Line size is fixed at four 32-bit words; only the number of sets is parameterised.
package data_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;

  localparam int ADDR_BITS  = 32;
  localparam int WORD_BITS  = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 4;

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int num_sets);
    return ADDR_BITS - INDEX_LSB - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one full-line write port.
// Reset clears only the valid and dirty bits; tags and data need no initial value.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = index_width(NUM_SETS),
  parameter int TAG_W    = tag_width(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic                 wr_dirty,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [NUM_SETS-1:0]  valid_bits;
  logic [NUM_SETS-1:0]  dirty_bits;
  logic [TAG_W-1:0]     tags  [NUM_SETS];
  logic [LINE_BITS-1:0] lines [NUM_SETS];

  // Any write installs a valid line; dirty distinguishes store-hit from fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
      dirty_bits[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = lines[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a single outstanding
// request, line-granular backing-memory interface and hit/miss counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_hit,
  output logic                 mem_req_valid,
  output logic                 mem_req_write,
  output logic [31:0]          mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_wdata,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_rdata,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IDX_W = index_width(NUM_SETS);
  localparam int TAG_W = tag_width(NUM_SETS);

  state_t state;
  state_t next_state;

  logic                     req_write_q;
  logic [31:OFFSET_LSB]     req_addr_q;
  logic [31:0]              req_wdata_q;
  logic                     first_lookup;
  logic                     accept;
  logic                     hit;
  logic                     unused_addr_bits;

  logic [IDX_W-1:0]         req_index;
  logic [TAG_W-1:0]         req_tag;
  logic [1:0]               req_word;

  logic                     rd_valid;
  logic                     rd_dirty;
  logic [TAG_W-1:0]         rd_tag;
  logic [LINE_BITS-1:0]     rd_data;
  logic                     wr_req;
  logic                     wr_dirty;
  logic [LINE_BITS-1:0]     wr_data;
  logic [LINE_BITS-1:0]     store_line;
  logic [31:0]              hit_word;

  assign unused_addr_bits = ^req_addr[OFFSET_LSB-1:0];

  assign req_index = req_addr_q[INDEX_LSB +: IDX_W];
  assign req_tag   = req_addr_q[31 -: TAG_W];
  assign req_word  = req_addr_q[OFFSET_LSB +: 2];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign hit_word  = rd_data[{req_word, 5'd0} +: WORD_BITS];

  data_cache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_req && !reset),
    .wr_index (req_index),
    .wr_dirty (wr_dirty),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = LOOKUP;
        else        next_state = IDLE;
      end
      LOOKUP: begin
        if (hit)                      next_state = IDLE;
        else if (rd_valid && rd_dirty) next_state = WRITEBACK;
        else                          next_state = FILL_REQ;
      end
      WRITEBACK: begin
        if (mem_req_ready) next_state = FILL_REQ;
        else               next_state = WRITEBACK;
      end
      FILL_REQ: begin
        if (mem_req_ready) next_state = FILL_WAIT;
        else               next_state = FILL_REQ;
      end
      FILL_WAIT: begin
        if (mem_resp_valid) next_state = LOOKUP;
        else                next_state = FILL_WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Store-hit line: the addressed word replaced, the rest unchanged.
  always_comb begin
    store_line = rd_data;
    store_line[{req_word, 5'd0} +: WORD_BITS] = req_wdata_q;
  end

  // Output logic; memory-side fields depend only on state and latched request,
  // so they hold steady for as long as the memory stalls.
  always_comb begin
    resp_valid    = 1'b0;
    resp_rdata    = 32'd0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_wdata = '0;
    wr_req        = 1'b0;
    wr_dirty      = 1'b0;
    wr_data       = store_line;
    case (state)
      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = hit_word;
          resp_hit   = first_lookup;
          wr_req     = req_write_q;
          wr_dirty   = 1'b1;
        end else begin
          resp_valid = 1'b0;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {rd_tag, req_index, 4'h0};
        mem_req_wdata = rd_data;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr_q[31:INDEX_LSB], 4'h0};
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          wr_req   = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = mem_resp_rdata;
        end else begin
          wr_req   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Request capture at acceptance; first_lookup marks the lookup that gets counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= 32'd0;
      first_lookup <= 1'b0;
    end else if (accept) begin
      req_write_q  <= req_write;
      req_addr_q   <= req_addr[31:OFFSET_LSB];
      req_wdata_q  <= req_wdata;
      first_lookup <= 1'b1;
    end else if (state == LOOKUP) begin
      first_lookup <= 1'b0;
    end
  end

  // Hit/miss counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if ((state == LOOKUP) && first_lookup) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios followed by random
// accesses, all checked against a set-indexed behavioural cache and memory model.
module tb_data_cache;

  localparam int NUM_SETS = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [31:0]  req_wdata = 32'd0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_hit;
  logic         mem_req_valid;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_rdata = 128'd0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  data_cache #(.NUM_SETS(NUM_SETS)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_hit       (resp_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  // Reference model: one entry per set plus a sparse backing memory.
  bit           mv     [NUM_SETS];
  bit           mdirty [NUM_SETS];
  logic [23:0]  mtag   [NUM_SETS];
  logic [127:0] mline  [NUM_SETS];
  logic [127:0] mem    [bit [31:0]];
  int           exp_hits = 0;
  int           exp_misses = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'h3C3C_0003, a ^ 32'h3C3C_0002, a ^ 32'h3C3C_0001, a ^ 32'h3C3C_0000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SETS; i++) begin
      mv[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_hits"}, 128'(hit_count), 128'(exp_hits));
    chk({tag, "_misses"}, 128'(miss_count), 128'(exp_misses));
  endtask

  // One memory-side handshake, entered on a negedge; returns on the negedge after acceptance.
  task automatic mem_xfer(input bit wr, input logic [31:0] a, input logic [127:0] d,
                          input int stall, input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mem_req_seen", 128'(ok), 128'd1);
    if (!ok) return;
    chk("mem_req_write", 128'(mem_req_write), 128'(wr));
    chk("mem_req_addr", 128'(mem_req_addr), 128'(a));
    if (wr) chk("mem_req_wdata", mem_req_wdata, d);
    for (int j = 0; j < stall; j++) begin
      if (poke && j == 0) begin
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_write = 1'($urandom);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall_valid", 128'(mem_req_valid), 128'd1);
      chk("stall_addr", 128'(mem_req_addr), 128'(a));
      chk("stall_write", 128'(mem_req_write), 128'(wr));
      chk("stall_no_resp", 128'(resp_valid), 128'd0);
      chk("stall_not_ready", 128'(req_ready), 128'd0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  // One CPU access, entered and left on a negedge with the cache idle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wb_stall, input int fill_stall, input int resp_delay,
                        input bit poke, input bit stop_in_fill);
    int s;
    int w;
    logic [23:0]  tag;
    logic [31:0]  la;
    logic [31:0]  va;
    logic [127:0] fill;
    bit ok;
    bit hit;
    s   = int'(addr[7:4]);
    w   = int'(addr[3:2]);
    tag = addr[31:8];
    la  = {addr[31:4], 4'h0};
    hit = mv[s] && (mtag[s] == tag);
    chk("idle_ready", 128'(req_ready), 128'd1);
    chk("idle_no_resp", 128'(resp_valid), 128'd0);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (hit) begin
      exp_hits++;
      chk("hit_resp_valid", 128'(resp_valid), 128'd1);
      chk("hit_resp_hit", 128'(resp_hit), 128'd1);
      chk("hit_no_mem", 128'(mem_req_valid), 128'd0);
      if (!wr) chk("hit_rdata", 128'(resp_rdata), 128'(mline[s][w*32 +: 32]));
    end else begin
      exp_misses++;
      chk("miss_no_resp", 128'(resp_valid), 128'd0);
      if (mv[s] && mdirty[s]) begin
        va = {mtag[s], 4'(s), 4'h0};
        mem_xfer(1'b1, va, mline[s], wb_stall, poke, ok);
        if (!ok) return;
        mem[va] = mline[s];
      end
      mem_xfer(1'b0, la, 128'd0, fill_stall, 1'b0, ok);
      if (!ok || stop_in_fill) return;
      for (int d = 0; d < resp_delay; d++) begin
        chk("wait_no_resp", 128'(resp_valid), 128'd0);
        @(negedge clk);
      end
      fill = mem_line(la);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = fill;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      mv[s] = 1'b1;
      mdirty[s] = 1'b0;
      mtag[s] = tag;
      mline[s] = fill;
      chk("retry_resp_valid", 128'(resp_valid), 128'd1);
      chk("retry_resp_hit", 128'(resp_hit), 128'd0);
      if (!wr) chk("retry_rdata", 128'(resp_rdata), 128'(mline[s][w*32 +: 32]));
    end
    if (wr) begin
      mline[s][w*32 +: 32] = wdata;
      mdirty[s] = 1'b1;
    end
    @(negedge clk);
    chk("done_no_resp", 128'(resp_valid), 128'd0);
    check_counters("done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    model_reset();
    mem[32'h10] = 128'h44444444_33333333_22222222_11111111;

    // Reset and first cycle after it
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_mem_write", 128'(mem_req_write), 128'd0);
    chk("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    chk("rst_resp_valid", 128'(resp_valid), 128'd0);
    check_counters("rst");

    // Cold load, hit, store hit, dirty eviction with busy poke and fill backpressure
    access(1'b0, 32'h10, 32'd0, 0, 0, 1, 1'b0, 1'b0);
    access(1'b0, 32'h14, 32'd0, 0, 0, 0, 1'b0, 1'b0);
    access(1'b1, 32'h18, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0);
    chk("wb_word2_model", mline[1][95:64], 128'hDEADBEEF);
    access(1'b0, 32'h110, 32'd0, 2, 5, 2, 1'b1, 1'b0);

    // Reset while waiting for a fill, stray response, then cold re-read
    access(1'b0, 32'h214, 32'd0, 0, 1, 0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    chk("fw_rst_ready", 128'(req_ready), 128'd1);
    chk("fw_rst_mem_valid", 128'(mem_req_valid), 128'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_no_resp", 128'(resp_valid), 128'd0);
    chk("stray_ready", 128'(req_ready), 128'd1);
    check_counters("stray");
    access(1'b0, 32'h14, 32'd0, 0, 0, 0, 1'b0, 1'b0);

    // Random traffic over a few tags per set to mix hits, clean and dirty misses
    for (int n = 0; n < 80; n++) begin
      a = {22'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15)), 4'($urandom)};
      access(1'($urandom), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
